alu_operand_acc_hold: RTL and testbench
=======================================

ALU_OPERAND_ACC_HOLD -- requirements
Module: alu_operand_acc_hold

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk_2 (single clock) and RES_N (async, active-low).
REQ-002 clk_2  input  1  phase-2 clock; all registers update on its rising edge.
REQ-003 RES_N  input  1  asynchronous active-low reset.
REQ-004 zero_add  input  1  load 0x00 into the A-input register.
REQ-005 sb_add  input  1  load sb_in into the A-input register.
REQ-006 sb_in  input  8  special-bus value seen by the block.
REQ-007 alu_result_n  input  8  active-low ALU result.
REQ-008 add_adl  input  1  drive hold contents onto ADL.
REQ-009 add_sb06  input  1  drive hold bits 6:0 onto SB bits 6:0.
REQ-010 add_sb7  input  1  drive hold bit 7 onto SB bit 7.
REQ-011 dec_adjust_in  input  8  decimal-adjust output, the accumulator load source.
REQ-012 sb_ac  input  1  load the accumulator.
REQ-013 ac_db  input  1  drive the accumulator onto DB.
REQ-014 ac_sb  input  1  drive the accumulator onto SB.
REQ-015 alu_a  output  8  A-input register contents, the ALU A operand.
REQ-016 hold_q  output  8  adder hold register contents, true polarity, for the decimal adjusters.
REQ-017 ac_q  output  8  accumulator contents.
REQ-018 adl_out/adl_oe  output  8/1  ADL drive value and enable.
REQ-019 sb_out/sb_oe  output  8/8  SB drive value and per-bit enables.
REQ-020 db_out/db_oe  output  8/1  DB drive value and enable.

Function
REQ-021 A-input register, on clk_2 rising edge: load 0x00 if zero_add=1; otherwise load sb_in if sb_add=1; otherwise hold its value.
REQ-022 If zero_add and sb_add are both 1, zero_add SHALL win and the register SHALL load 0x00.
REQ-023 Adder hold register SHALL load ~alu_result_n on every clk_2 rising edge, unconditionally.
REQ-024 hold_q SHALL equal the hold register contents.
REQ-025 The hold register SHALL have one-cycle latency from alu_result_n to hold_q.
REQ-026 Accumulator SHALL load dec_adjust_in on a clk_2 rising edge when sb_ac=1; otherwise it SHALL hold its value.
REQ-027 adl_oe SHALL equal add_adl, and adl_out SHALL equal hold_q when add_adl=1, else 0xFF.
REQ-028 db_oe SHALL equal ac_db, and db_out SHALL equal ac_q when ac_db=1, else 0xFF.
REQ-029 SB per-bit enables: sb_oe[6:0] = add_sb06 | ac_sb; sb_oe[7] = add_sb7 | ac_sb.
REQ-030 SB model: precharged bus with open-drain sources; sb_out[i] SHALL be the AND of every enabled source bit, and 1 when no source is enabled.
REQ-031 Hold and accumulator both driving SB SHALL give sb_out = hold_q & ac_q on the enabled bits, with no error flagged.
REQ-032 All drive outputs and enables SHALL be combinational from the current register contents and control inputs.
REQ-033 All drive outputs SHALL be valid in the same cycle the control inputs are asserted.
REQ-034 Registers are 8-bit with no arithmetic; values SHALL neither wrap nor saturate.

Reset
REQ-035 While RES_N=0, alu_a, hold_q and ac_q SHALL be 0x00 immediately, regardless of clk_2.
REQ-036 Drive enables SHALL follow the control inputs during reset.
REQ-037 Asserting reset mid-operation SHALL override any pending load.
REQ-038 Following the first clk_2 rising edge after RES_N deasserts, the block SHALL behave per REQ-021 to REQ-026.

Verification
REQ-039 sb_in=0x5A, sb_add=1, one clk_2 edge: alu_a=0x5A; then zero_add=1, sb_add=1, one edge: alu_a=0x00.
REQ-040 alu_result_n=0x3C, one edge: hold_q=0xC3; add_adl=1 gives adl_oe=1 and adl_out=0xC3.
REQ-041 hold_q=0xC3, add_sb06=1, add_sb7=0: sb_oe=0x7F and sb_out=0xC3; then add_sb7=1: sb_oe=0xFF and sb_out=0xC3.
REQ-042 dec_adjust_in=0x99, sb_ac=1, one edge: ac_q=0x99; ac_db=1 gives db_out=0x99; sb_ac=0 with dec_adjust_in=0x11 keeps ac_q=0x99.
REQ-043 hold_q=0xF0, ac_q=0x3C, add_sb06=add_sb7=ac_sb=1: sb_out=0x30 and sb_oe=0xFF.
REQ-044 Registers loaded nonzero, RES_N pulsed low between edges: alu_a, hold_q and ac_q go to 0x00 asynchronously.

Source files
------------

// File: rtl/alu_operand_acc_hold.sv
// ALU A-input register, adder hold register and accumulator,
// with open-drain drivers onto the ADL, SB and DB buses.
module alu_operand_acc_hold (
    input  logic       clk_2,
    input  logic       RES_N,
    input  logic       zero_add,
    input  logic       sb_add,
    input  logic [7:0] sb_in,
    input  logic [7:0] alu_result_n,
    input  logic       add_adl,
    input  logic       add_sb06,
    input  logic       add_sb7,
    input  logic [7:0] dec_adjust_in,
    input  logic       sb_ac,
    input  logic       ac_db,
    input  logic       ac_sb,
    output logic [7:0] alu_a,
    output logic [7:0] hold_q,
    output logic [7:0] ac_q,
    output logic [7:0] adl_out,
    output logic       adl_oe,
    output logic [7:0] sb_out,
    output logic [7:0] sb_oe,
    output logic [7:0] db_out,
    output logic       db_oe
);

    logic [7:0] a_q, a_d;
    logic [7:0] add_q, add_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] hold_sb_en;
    logic [7:0] sb_hold_drv;
    logic [7:0] sb_ac_drv;

    always_comb begin
        a_d = a_q;
        if (zero_add) begin
            a_d = 8'h00;
        end else if (sb_add) begin
            a_d = sb_in;
        end
    end

    // ALU result arrives inverted; the hold register stores true polarity
    assign add_d = ~alu_result_n;

    assign acc_d = sb_ac ? dec_adjust_in : acc_q;

    always_ff @(posedge clk_2 or negedge RES_N) begin
        if (!RES_N) begin
            a_q   <= 8'h00;
            add_q <= 8'h00;
            acc_q <= 8'h00;
        end else begin
            a_q   <= a_d;
            add_q <= add_d;
            acc_q <= acc_d;
        end
    end

    assign alu_a  = a_q;
    assign hold_q = add_q;
    assign ac_q   = acc_q;

    assign adl_oe  = add_adl;
    assign adl_out = add_adl ? add_q : 8'hFF;

    assign db_oe  = ac_db;
    assign db_out = ac_db ? acc_q : 8'hFF;

    // Precharged SB: an undriven bit reads 1, multiple drivers wire-AND
    assign hold_sb_en  = {add_sb7, {7{add_sb06}}};
    assign sb_hold_drv = add_q | ~hold_sb_en;
    assign sb_ac_drv   = ac_sb ? acc_q : 8'hFF;
    assign sb_out      = sb_hold_drv & sb_ac_drv;
    assign sb_oe       = hold_sb_en | {8{ac_sb}};

endmodule

// File: tb/tb_alu_operand_acc_hold.sv
// Scoreboard bench for alu_operand_acc_hold: expectations are
// queued when stimulus is driven and compared after the DUT settles.
module tb_alu_operand_acc_hold;

    logic       clk_2 = 1'b0;
    logic       RES_N;
    logic       zero_add, sb_add;
    logic [7:0] sb_in, alu_result_n;
    logic       add_adl, add_sb06, add_sb7;
    logic [7:0] dec_adjust_in;
    logic       sb_ac, ac_db, ac_sb;
    logic [7:0] alu_a, hold_q, ac_q, adl_out, sb_out, sb_oe, db_out;
    logic       adl_oe, db_oe;

    int total = 0;
    int bad   = 0;

    logic [7:0] ma, mh, mac;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] exp;
    } exp_t;

    exp_t sbq[$];

    always #5 clk_2 = ~clk_2;

    alu_operand_acc_hold dut (
        .clk_2        (clk_2),
        .RES_N        (RES_N),
        .zero_add     (zero_add),
        .sb_add       (sb_add),
        .sb_in        (sb_in),
        .alu_result_n (alu_result_n),
        .add_adl      (add_adl),
        .add_sb06     (add_sb06),
        .add_sb7      (add_sb7),
        .dec_adjust_in(dec_adjust_in),
        .sb_ac        (sb_ac),
        .ac_db        (ac_db),
        .ac_sb        (ac_sb),
        .alu_a        (alu_a),
        .hold_q       (hold_q),
        .ac_q         (ac_q),
        .adl_out      (adl_out),
        .adl_oe       (adl_oe),
        .sb_out       (sb_out),
        .sb_oe        (sb_oe),
        .db_out       (db_out),
        .db_oe        (db_oe)
    );

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%02h want=%02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] obs(input int sel);
        case (sel)
            0: return alu_a;
            1: return hold_q;
            2: return ac_q;
            3: return adl_out;
            4: return {7'd0, adl_oe};
            5: return db_out;
            6: return {7'd0, db_oe};
            7: return sb_out;
            default: return sb_oe;
        endcase
    endfunction

    task automatic push(input string tag, input int sel,
                        input logic [7:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk(e.tag, obs(e.sel), e.exp);
        end
    endtask

    task automatic push_regs(input string pfx);
        push({pfx, ".alu_a"}, 0, ma);
        push({pfx, ".hold_q"}, 1, mh);
        push({pfx, ".ac_q"}, 2, mac);
    endtask

    // Bus expectations from the model registers and current controls
    task automatic push_bus(input string pfx);
        logic [7:0] so, se;
        for (int i = 0; i < 8; i++) begin
            logic hen;
            hen = (i == 7) ? add_sb7 : add_sb06;
            se[i] = hen || ac_sb;
            so[i] = 1'b1;
            if (hen && !mh[i]) so[i] = 1'b0;
            if (ac_sb && !mac[i]) so[i] = 1'b0;
        end
        push({pfx, ".adl_out"}, 3, add_adl ? mh : 8'hFF);
        push({pfx, ".adl_oe"}, 4, {7'd0, add_adl});
        push({pfx, ".db_out"}, 5, ac_db ? mac : 8'hFF);
        push({pfx, ".db_oe"}, 6, {7'd0, ac_db});
        push({pfx, ".sb_out"}, 7, so);
        push({pfx, ".sb_oe"}, 8, se);
    endtask

    task automatic step(input string pfx,
                        input logic za, input logic sa,
                        input logic [7:0] sbi, input logic [7:0] arn,
                        input logic [7:0] dec, input logic sac,
                        input logic adl, input logic s06, input logic s7,
                        input logic adb, input logic asb);
        zero_add      = za;
        sb_add        = sa;
        sb_in         = sbi;
        alu_result_n  = arn;
        dec_adjust_in = dec;
        sb_ac         = sac;
        add_adl       = adl;
        add_sb06      = s06;
        add_sb7       = s7;
        ac_db         = adb;
        ac_sb         = asb;
        push_bus({pfx, ".pre"});
        #1;
        drain();
        if (za) ma = 8'h00;
        else if (sa) ma = sbi;
        mh = ~arn;
        if (sac) mac = dec;
        push_regs(pfx);
        push_bus(pfx);
        @(posedge clk_2);
        #1;
        drain();
    endtask

    initial begin
        RES_N = 1'b0;
        zero_add = 0; sb_add = 0; sb_in = 8'h00;
        alu_result_n = 8'h00; dec_adjust_in = 8'h00;
        sb_ac = 0; add_adl = 1; add_sb06 = 0; add_sb7 = 0;
        ac_db = 1; ac_sb = 0;
        ma = 0; mh = 0; mac = 0;

        #2;
        push_regs("rst");
        push_bus("rst");
        drain();

        // loads requested during reset must be ignored
        sb_add = 1; sb_in = 8'hA5; sb_ac = 1; dec_adjust_in = 8'h77;
        @(posedge clk_2);
        #1;
        push_regs("rst_edge");
        drain();
        #3;
        RES_N = 1'b1;
        @(posedge clk_2);
        #1;
        ma = 8'hA5; mh = 8'hFF; mac = 8'h77;
        push_regs("post_rst");
        drain();

        step("a_load", 0, 1, 8'h5A, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        step("a_zero", 1, 1, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        step("a_hold", 0, 0, 8'h33, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        step("hold", 0, 0, 8'h00, 8'h3C, 8'h00, 0, 1, 0, 0, 0, 0);
        step("adl", 0, 0, 8'h00, 8'h3C, 8'h00, 0, 1, 0, 0, 0, 0);
        step("sb06", 0, 0, 8'h00, 8'h3C, 8'h00, 0, 0, 1, 0, 0, 0);
        step("sb7", 0, 0, 8'h00, 8'h3C, 8'h00, 0, 0, 1, 1, 0, 0);
        step("ac_ld", 0, 0, 8'h00, 8'h3C, 8'h99, 1, 0, 0, 0, 1, 0);
        step("ac_keep", 0, 0, 8'h00, 8'h3C, 8'h11, 0, 0, 0, 0, 1, 0);
        step("both_ld", 0, 0, 8'h00, 8'h0F, 8'h3C, 1, 0, 0, 0, 0, 0);
        step("both_sb", 0, 0, 8'h00, 8'h0F, 8'h00, 0, 0, 1, 1, 0, 1);
        step("ac_sb", 0, 0, 8'h00, 8'h0F, 8'h00, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 40; i++) begin
            logic [10:0] c;
            c = 11'($urandom);
            step("rnd", c[0], c[1], 8'($urandom), 8'($urandom),
                 8'($urandom), c[2], c[3], c[4], c[5], c[6], c[7]);
        end

        step("pre_ar", 0, 1, 8'hC7, 8'h12, 8'h5E, 1, 0, 0, 0, 0, 0);
        #2;
        RES_N = 1'b0;
        ma = 0; mh = 0; mac = 0;
        #1;
        push_regs("async");
        drain();
        #4;
        RES_N = 1'b1;
        step("after_ar", 0, 1, 8'h6B, 8'h80, 8'h24, 1, 1, 1, 1, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
